// File: rtl/obi_apb_bridge.sv
// OBI to APB4 bridge: one outstanding transfer, address-decoded completer select,
// optional ACCESS-phase timeout that answers with an error response.
module obi_apb_bridge #(
  parameter int unsigned AW      = 32,
  parameter int unsigned DW      = 32,
  parameter int unsigned NSLV    = 4,
  parameter int unsigned SEL_LSB = 12,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 obi_req_i,
  output logic                 obi_gnt_o,
  input  logic [AW-1:0]        obi_addr_i,
  input  logic                 obi_we_i,
  input  logic [DW/8-1:0]      obi_be_i,
  input  logic [DW-1:0]        obi_wdata_i,
  output logic                 obi_rvalid_o,
  output logic [DW-1:0]        obi_rdata_o,
  output logic                 obi_err_o,
  output logic [AW-1:0]        apb_paddr_o,
  output logic [2:0]           apb_pprot_o,
  output logic [NSLV-1:0]      apb_psel_o,
  output logic                 apb_penable_o,
  output logic                 apb_pwrite_o,
  output logic [DW-1:0]        apb_pwdata_o,
  output logic [DW/8-1:0]      apb_pstrb_o,
  input  logic [NSLV*DW-1:0]   apb_prdata_i,
  input  logic [NSLV-1:0]      apb_pready_i,
  input  logic [NSLV-1:0]      apb_pslverr_i
);

  localparam int unsigned BW = DW / 8;
  localparam int unsigned SW = (NSLV > 1) ? $clog2(NSLV) : 1;
  localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_e;

  state_e         state_q, state_d;
  logic [AW-1:0]  addr_q;
  logic           we_q;
  logic [BW-1:0]  be_q;
  logic [DW-1:0]  wdata_q;
  logic [SW-1:0]  idx_q, sel_idx;
  logic [DW-1:0]  rdata_q, rdata_d;
  logic           err_q, err_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           hs, dec_err, expired;
  logic           ready_sel, slverr_sel;
  logic [DW-1:0]  prdata_sel;

  // A single completer needs no select field.
  generate
    if (NSLV > 1) begin : g_sel
      assign sel_idx = obi_addr_i[SEL_LSB +: SW];
    end else begin : g_nosel
      assign sel_idx = '0;
    end
  endgenerate

  assign hs         = obi_gnt_o;
  assign dec_err    = 32'(sel_idx) >= NSLV;
  assign ready_sel  = apb_pready_i[idx_q];
  assign slverr_sel = apb_pslverr_i[idx_q];
  assign prdata_sel = apb_prdata_i[idx_q*DW +: DW];
  assign expired    = (TIMEOUT != 0) && (cnt_q == CW'(TIMEOUT - 1));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      addr_q  <= '0;
      we_q    <= 1'b0;
      be_q    <= '0;
      wdata_q <= '0;
      idx_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      // Read strobes and write data are zeroed at capture so APB sees clean values.
      if (hs) begin
        addr_q  <= obi_addr_i;
        we_q    <= obi_we_i;
        be_q    <= obi_we_i ? obi_be_i : '0;
        wdata_q <= obi_we_i ? obi_wdata_i : '0;
        idx_q   <= sel_idx;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (hs) begin
          rdata_d = '0;
          err_d   = dec_err;
          state_d = dec_err ? RESP : SETUP;
        end
      end
      SETUP: begin
        cnt_d   = '0;
        state_d = ACCESS;
      end
      ACCESS: begin
        // pready takes priority over an expiring timeout.
        if (ready_sel) begin
          rdata_d = we_q ? '0 : prdata_sel;
          err_d   = slverr_sel;
          state_d = RESP;
        end else if (expired) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign obi_gnt_o     = (state_q == IDLE) && obi_req_i && !rst_i;
  assign obi_rvalid_o  = (state_q == RESP);
  assign obi_rdata_o   = obi_rvalid_o ? rdata_q : '0;
  assign obi_err_o     = obi_rvalid_o && err_q;
  assign apb_paddr_o   = addr_q;
  assign apb_pprot_o   = 3'b010;
  assign apb_pwrite_o  = we_q;
  assign apb_pwdata_o  = wdata_q;
  assign apb_pstrb_o   = be_q;
  assign apb_penable_o = (state_q == ACCESS);
  assign apb_psel_o    = ((state_q == SETUP) || (state_q == ACCESS)) ? (NSLV'(1) << idx_q) : '0;

endmodule

// File: doc/obi_apb_bridge.md
OBI_APB_BRIDGE -- requirements
Module: obi_apb_bridge

Parameters
REQ-001 SHALL have parameter AW, default 32, giving the address width in bits.
REQ-002 SHALL have parameter DW, default 32, giving the data width in bits; legal values are 8, 16 and 32.
REQ-003 SHALL have parameter NSLV, default 4, giving the number of APB completers; legal range is 1..16.
REQ-004 SHALL have parameter SEL_LSB, default 12, giving the lowest address bit of the completer-select field; the field is clog2(NSLV) bits wide, or 0 bits when NSLV=1.
REQ-005 SHALL have parameter TIMEOUT, default 16, giving the maximum number of ACCESS-phase cycles; 0 disables the timeout.

Interface
REQ-006 SHALL have clk_i, input, 1 bit: the single clock.
REQ-007 SHALL have rst_i, input, 1 bit: reset, synchronous and active-high.
REQ-008 SHALL have obi_req_i in 1, obi_gnt_o out 1, obi_addr_i in AW, obi_we_i in 1, obi_be_i in DW/8, obi_wdata_i in DW: the OBI request channel.
REQ-009 SHALL have obi_rvalid_o out 1, obi_rdata_o out DW, obi_err_o out 1: the OBI response channel.
REQ-010 SHALL have apb_paddr_o out AW, apb_pprot_o out 3, apb_psel_o out NSLV, apb_penable_o out 1, apb_pwrite_o out 1, apb_pwdata_o out DW, apb_pstrb_o out DW/8: the APB4 requester outputs.
REQ-011 SHALL have apb_prdata_i in NSLV*DW (completer k at bits [k*DW +: DW]), apb_pready_i in NSLV, apb_pslverr_i in NSLV: the per-completer APB inputs.

Function
REQ-012 SHALL implement the FSM states IDLE, SETUP, ACCESS and RESP, with exactly one transaction outstanding at a time.
REQ-013 IDLE: obi_gnt_o SHALL equal obi_req_i (combinational); on the handshake cycle, addr, we, be and wdata SHALL be captured into registers and the select index computed as addr[SEL_LSB +: clog2(NSLV)].
REQ-014 IDLE with the handshake and select index < NSLV SHALL transition to SETUP.
REQ-015 IDLE with the handshake and select index >= NSLV (decode error) SHALL transition directly to RESP with err=1 and rdata=0; no psel SHALL be asserted.
REQ-016 obi_gnt_o SHALL be 0 in SETUP, ACCESS and RESP.
REQ-017 SETUP SHALL assert one-hot apb_psel_o[idx]=1 with apb_penable_o=0 for exactly one cycle, then transition to ACCESS.
REQ-018 ACCESS SHALL assert apb_psel_o[idx]=1 and apb_penable_o=1, and SHALL hold until apb_pready_i[idx]=1; it SHALL then capture prdata[idx] (reads only; writes capture 0) and pslverr[idx], and transition to RESP.
REQ-019 A timeout counter SHALL clear on entry to ACCESS and increment every ACCESS cycle with pready=0.
REQ-020 When TIMEOUT>0 and the count reaches TIMEOUT-1 with pready still 0, ACCESS SHALL end that cycle: psel and penable drop next cycle, RESP gives err=1 and rdata=0.
REQ-021 pready arriving in the same cycle as timeout expiry SHALL win: normal completion with that cycle's pslverr.
REQ-022 RESP SHALL assert obi_rvalid_o=1 for exactly one cycle with the registered obi_rdata_o and obi_err_o, then transition to IDLE.
REQ-023 obi_rdata_o and obi_err_o SHALL be 0 whenever obi_rvalid_o=0.
REQ-024 A request pending during RESP SHALL be granted in the following IDLE cycle; the minimum accept-to-accept period is 4 cycles.
REQ-025 apb_paddr_o, apb_pwrite_o, apb_pwdata_o and apb_pstrb_o SHALL be driven from the captured registers and SHALL be stable from SETUP through the last ACCESS cycle.
REQ-026 apb_pstrb_o SHALL be 0 for reads; apb_pwdata_o SHALL be 0 for reads.
REQ-027 apb_pprot_o SHALL be constant 3'b010.
REQ-028 Minimum latency SHALL be: handshake in cycle 0, SETUP in cycle 1, ACCESS with pready in cycle 2, rvalid in cycle 3.

Reset
REQ-029 With rst_i=1 at a clock edge, the FSM SHALL go to IDLE and the timeout counter and all captured registers SHALL clear to 0.
REQ-030 During and after reset: obi_gnt_o=0 while rst_i=1; obi_rvalid_o=0, obi_err_o=0, obi_rdata_o=0, apb_psel_o=0 and apb_penable_o=0.
REQ-031 Reset during SETUP, ACCESS or RESP SHALL abort the transfer with no rvalid issued; the first post-reset request SHALL be served normally.

Verification
REQ-032 Read to addr 0x0000_2004 (idx 2), pready=1 in the first ACCESS cycle, prdata[2]=0xDEADBEEF -> psel=4'b0100 for cycles 1-2, penable high in cycle 2 only, rvalid in cycle 3 with rdata=0xDEADBEEF and err=0.
REQ-033 Write to idx 1 with wdata=0x12345678, be=4'b0011, pready delayed 3 cycles -> pwdata and pstrb stable throughout ACCESS, rvalid one cycle after pready with rdata=0 and err=0.
REQ-034 TIMEOUT=16, completer never ready -> exactly 16 ACCESS cycles, then rvalid with err=1 and rdata=0; a second variant with pready coinciding with the 16th cycle -> normal completion.
REQ-035 NSLV=3, addr selecting idx 3 -> no psel asserted, rvalid one cycle after the grant with err=1; a pslverr=1 completion -> err=1 with the captured rdata.
REQ-036 Back-to-back requests with req held high -> gnt pulses exactly every 4 cycles; rst_i asserted mid-ACCESS -> psel, penable and rvalid all 0 next cycle, and a subsequent request completes correctly.
